// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - operand/command and HI/LO result bundle between EX stage and mdu
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output A, B, MDOp, start,
        input  busy, HI, LO
    );

    modport slave (
        input  A, B, MDOp, start,
        output busy, HI, LO
    );
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - fixed-latency multiply/divide unit holding the HI/LO registers
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset_n,
    mdu_if.slave md
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t             state, nx_state;
    logic [CNT_W-1:0]   cnt, nx_cnt;
    logic [31:0]        hi, lo, nx_hi, nx_lo;
    logic [31:0]        hi_next, lo_next, nx_hi_next, nx_lo_next;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [31:0] div_q, div_r, divu_q, divu_r;
    logic        b_zero;

    // Arithmetic datapath on the operands as presented; results are only kept at start
    always_comb begin
        prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
        prod_u = {32'd0, md.A} * {32'd0, md.B};
        b_zero = (md.B == 32'd0);
        // Signed divide via magnitudes: truncation toward zero, remainder takes the dividend's
        // sign. 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0 without a special case.
        a_mag  = md.A[31] ? (32'd0 - md.A) : md.A;
        b_mag  = md.B[31] ? (32'd0 - md.B) : md.B;
        q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
        r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
        if (b_zero) begin
            div_q  = 32'hFFFF_FFFF;
            div_r  = md.A;
            divu_q = 32'hFFFF_FFFF;
            divu_r = md.A;
        end else begin
            div_q  = (md.A[31] ^ md.B[31]) ? (32'd0 - q_mag) : q_mag;
            div_r  = md.A[31] ? (32'd0 - r_mag) : r_mag;
            divu_q = md.A / md.B;
            divu_r = md.A % md.B;
        end
    end

    // Next-state logic: launch, count down, retire into HI/LO, and the mthi/mtlo moves
    always_comb begin
        nx_state   = state;
        nx_cnt     = cnt;
        nx_hi      = hi;
        nx_lo      = lo;
        nx_hi_next = hi_next;
        nx_lo_next = lo_next;
        case (state)
            IDLE: begin
                if (md.start) begin
                    case (md.MDOp)
                        OP_MULT: begin
                            {nx_hi_next, nx_lo_next} = prod_s;
                            nx_cnt   = CNT_W'(MULT_CYCLES - 1);
                            nx_state = RUN;
                        end
                        OP_MULTU: begin
                            {nx_hi_next, nx_lo_next} = prod_u;
                            nx_cnt   = CNT_W'(MULT_CYCLES - 1);
                            nx_state = RUN;
                        end
                        OP_DIV: begin
                            nx_hi_next = div_r;
                            nx_lo_next = div_q;
                            nx_cnt     = CNT_W'(DIV_CYCLES - 1);
                            nx_state   = RUN;
                        end
                        OP_DIVU: begin
                            nx_hi_next = divu_r;
                            nx_lo_next = divu_q;
                            nx_cnt     = CNT_W'(DIV_CYCLES - 1);
                            nx_state   = RUN;
                        end
                        OP_MTHI: nx_hi = md.A;
                        OP_MTLO: nx_lo = md.A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // start is ignored here; the hazard unit should never issue one
                if (cnt == '0) begin
                    nx_hi    = hi_next;
                    nx_lo    = lo_next;
                    nx_state = IDLE;
                end else begin
                    nx_cnt = cnt - 1'b1;
                end
            end
            default: nx_state = IDLE;
        endcase
    end

    // State and architectural registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_next <= 32'd0;
            lo_next <= 32'd0;
        end else begin
            state   <= nx_state;
            cnt     <= nx_cnt;
            hi      <= nx_hi;
            lo      <= nx_lo;
            hi_next <= nx_hi_next;
            lo_next <= nx_lo_next;
        end
    end

    assign md.busy = (state == RUN);
    assign md.HI   = hi;
    assign md.LO   = lo;
endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit that sits beside the ALU in the EX stage of the pipelined MIPS core.
- Consumes the same forwarded rs/rt operands (A, B) and holds the architectural HI/LO registers for mult, multu, div, divu, mthi and mtlo.
- Operations run for a fixed number of cycles and assert busy throughout.
- The hazard unit stalls any later MD instruction and any mfhi/mflo while busy is high or start is high.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (must be >= 1).
- DIV_CYCLES, 10, cycles busy stays high for div/divu (must be >= 1).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- A  input  32  operand from rs (forwarded)
- B  input  32  operand from rt (forwarded)
- MDOp  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 no-op
- start  input  1  qualifies MDOp for one cycle (EX-stage instruction valid)
- busy  output  1  operation in progress
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Reset (reset_n low, asynchronous): HI=0, LO=0, busy=0, cycle counter=0, state IDLE, pending result registers=0.
- Reset asserted mid-operation aborts the operation; HI/LO are forced to 0 and are not updated by the aborted operation.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter active.
- IDLE, start=1, MDOp in {000..011}, sampled at edge t:
  - Compute the result from A/B as sampled at edge t and latch it into internal hi_next/lo_next.
  - Load counter with MULT_CYCLES-1 (mult/multu) or DIV_CYCLES-1 (div/divu); go to RUN.
  - busy is high from after edge t through edge t+N, where N = MULT_CYCLES or DIV_CYCLES.
- RUN: decrement the counter each edge. At the edge where counter==0, write HI<=hi_next and LO<=lo_next, busy<=0, and return to IDLE.
- Timing consequence: new HI/LO values are visible from edge t+N onward, in the same cycle busy falls. For N=1, busy is high for exactly one cycle.
- IDLE, start=1, MDOp=100 (mthi): HI<=A at the next edge; LO unchanged; busy stays 0.
- IDLE, start=1, MDOp=101 (mtlo): LO<=A at the next edge; HI unchanged; busy stays 0.
- MDOp=110/111, or start=0: no state change.
- start while in RUN is ignored, whatever MDOp is; the stall logic guarantees it does not occur, and the verification bench checks that it is ignored.
- A and B changing during RUN has no effect, since the result was latched at start.
- Arithmetic rules:
  - mult: 64-bit signed product of A and B; {HI,LO}=product.
  - multu: 64-bit unsigned product; {HI,LO}=product.
  - div: signed. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend (A).
  - divu: unsigned. LO=A/B, HI=A%B.
- Divide by zero (B==0):
  - divu: LO=32'hFFFFFFFF, HI=A.
  - div: LO=32'hFFFFFFFF, HI=A.
  - The operation still takes DIV_CYCLES cycles.
- Signed overflow (div with A=32'h80000000, B=32'hFFFFFFFF): LO=32'h80000000, HI=0.
- HI/LO change only at the three events listed above (operation completion, mthi, mtlo) or on reset.

Test Plan:
- Reset then idle: reset_n low for 2 cycles, then high, start=0 for 5 cycles -> HI=0, LO=0, busy=0 throughout.
- mult signed: A=32'hFFFFFFFE (-2), B=3, start for 1 cycle -> busy high exactly 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA. multu with the same operands -> HI=32'h00000002, LO=32'hFFFFFFFA.
- div signed/unsigned:
  - div A=-7 (32'hFFFFFFF9), B=2 -> busy 10 cycles; LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
  - divu with the same operands -> LO=32'h7FFFFFFC, HI=1.
- Boundary divides:
  - divu A=100, B=0 -> LO=32'hFFFFFFFF, HI=100.
  - div A=32'h80000000, B=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- mthi/mtlo and ignored start:
  - mthi A=32'h12345678 -> next edge HI=32'h12345678, busy=0.
  - Then start a mult of 2*3, and on cycle 2 of RUN pulse start with MDOp=mtlo, A=32'hDEAD -> the mtlo is ignored; after 5 cycles LO=6, HI=0.
- Reset mid-operation: start divu 50/7, assert reset_n low on cycle 4 of RUN -> busy drops immediately (asynchronously), HI=LO=0. After release, no late HI/LO update occurs over the next 10 cycles.
